// File: rtl/i2c_pkg.sv
// Shared widths and arbiter state encoding for the I2C bus arbiter.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StResp
  } arb_state_e;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after rr_ptr, with wrap.
module i2c_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  int unsigned        idx;
  logic [IDX_W-1:0]   cand;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    cand   = '0;
    // Walk NUM_REQ positions starting just after the last grant; the pointer itself comes last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = IDX_W'(idx);
      if (!any && valid[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters, with bus_busy
// gating, per-command timeout and per-requester completion/error pulses.
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rnw,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0]  req_addr,
  input  logic [I2C_DATA_W*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_done,
  output logic [NUM_REQ-1:0]             rsp_err,
  input  logic                           bus_busy,
  output logic                           m_write_en,
  output logic                           m_read_en,
  output logic [I2C_ADDR_W-1:0]          m_addr,
  output logic [I2C_DATA_W-1:0]          m_data,
  input  logic                           m_done,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           active
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       grant_q;
  logic                   rnw_q;
  logic [I2C_ADDR_W-1:0]  addr_q;
  logic [I2C_DATA_W-1:0]  data_q;
  logic                   err_q, err_d;
  logic                   active_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [IDX_W-1:0]       pick_winner;
  logic                   pick_any;
  logic                   grant_fire;
  logic                   sel_rnw;
  logic [I2C_ADDR_W-1:0]  sel_addr;
  logic [I2C_DATA_W-1:0]  sel_data;

  i2c_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // A grant during the reset cycle would be lost, so the accept pulse is suppressed there.
  assign grant_fire = (state_q == StIdle) && pick_any && !bus_busy && !rst;

  always_comb begin
    sel_rnw  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_winner == IDX_W'(i)) begin
        sel_rnw  = req_rnw[i];
        sel_addr = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        sel_data = req_data[i*I2C_DATA_W +: I2C_DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (grant_fire) begin
          state_d = StCmd;
        end
      end
      StCmd: begin
        // Completion takes precedence over a coincident timeout.
        if (m_done) begin
          state_d = StResp;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = StResp;
          err_d   = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      grant_q  <= '0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= (state_q == StCmd) ? cnt_q + CNT_W'(1) : '0;
      if (grant_fire) begin
        grant_q  <= pick_winner;
        rnw_q    <= sel_rnw;
        addr_q   <= sel_addr;
        data_q   <= sel_data;
        active_q <= 1'b1;
      end
      if (state_q == StResp) begin
        rr_ptr_q <= grant_q;
        active_q <= 1'b0;
      end
    end
  end

  always_comb begin
    req_ready  = grant_fire ? (NUM_REQ'(1) << pick_winner) : '0;
    rsp_done   = (state_q == StResp) ? (NUM_REQ'(1) << grant_q) : '0;
    rsp_err    = (state_q == StResp && err_q) ? (NUM_REQ'(1) << grant_q) : '0;
    m_write_en = (state_q == StCmd) && !rnw_q;
    m_read_en  = (state_q == StCmd) && rnw_q;
    m_addr     = addr_q;
    m_data     = data_q;
    grant_id   = grant_q;
    active     = active_q;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
Shares the single I2C master (write_en/read_en/addr/data/done command interface) between NUM_REQ independent requesters. It arbitrates round-robin, gates issue on external bus_busy, and holds the selected command on the master interface until done or timeout. It then returns a per-requester completion/error pulse. It sits between software- or FSM-side requesters and the I2C master, one instance per physical bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 4096, max cycles a command may stay outstanding before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  requester i has a command pending
req_rnw  in  NUM_REQ  1=read, 0=write, per requester
req_addr  in  7*NUM_REQ  7-bit slave address, requester i at [7*i +: 7]
req_data  in  8*NUM_REQ  write data, requester i at [8*i +: 8]
req_ready  out  NUM_REQ  one-cycle accept pulse to granted requester
rsp_done  out  NUM_REQ  one-cycle completion pulse
rsp_err  out  NUM_REQ  qualifies rsp_done: 1=timed out
bus_busy  in  1  I2C bus occupied by another master
m_write_en  out  1  write enable to I2C master
m_read_en  out  1  read enable to I2C master
m_addr  out  7  slave address to I2C master
m_data  out  8  write data to I2C master
m_done  in  1  I2C master completion
grant_id  out  $clog2(NUM_REQ)  index of current/last grant
active  out  1  command outstanding

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - All outputs go to 0 and state goes to IDLE.
  - rr_ptr (last grant) goes to NUM_REQ-1, so requester 0 has first priority.
  - Timeout counter clears.
- States: IDLE, CMD, RESP.
- IDLE:
  - If any req_valid and !bus_busy: pick winner w, the first valid index after rr_ptr with wrap.
  - Same edge: pulse req_ready[w] for 1 cycle, latch req_rnw/addr/data of w, grant_id<=w, active<=1, go to CMD.
  - If bus_busy=1: no grant and no ready; re-evaluate every cycle.
- CMD:
  - m_write_en = !rnw_q and m_read_en = rnw_q, held level for the whole state. Never both high.
  - m_addr/m_data are stable for the whole state.
  - Counter increments each cycle.
  - On m_done=1: go to RESP with err=0.
  - Else when the counter reaches TIMEOUT_CYC-1: go to RESP with err=1.
  - If m_done and timeout coincide, done wins (err=0).
  - bus_busy and req_valid changes are ignored while in CMD.
- RESP (1 cycle):
  - Enables are 0; m_addr/m_data hold their values.
  - rsp_done[w]=1, rsp_err[w]=err, rr_ptr<=w, active<=0, go to IDLE.
- Latency:
  - Accept edge N, enables high from cycle N+1.
  - rsp_done is high the cycle after m_done is sampled.
  - Minimum turnaround is 3 cycles plus master latency. A new grant is possible in the cycle following RESP.
- Boundaries:
  - m_done in IDLE/RESP is ignored.
  - req_valid dropped before grant means no grant.
  - req_valid held after rsp_done re-requests; round-robin ordering prevents starvation.
  - No retry after timeout.
  - Only the granted index ever sees ready/done/err.
  - Reset in CMD aborts without rsp_done; enables are 0 the next cycle.

Decomposition:
- Package i2c_pkg:
  - I2C_ADDR_W=7, I2C_DATA_W=8.
  - Arbiter state enum/localparams (IDLE, CMD, RESP).
- Sub-module i2c_rr_pick:
  - Combinational round-robin picker.
  - Inputs: valid vector, rr_ptr. Outputs: winner index, any.
  - Parameterised by NUM_REQ.
- Arbiter body: FSM, latches, counter (~200 lines total).

Test Plan:
- Write: req0 valid, rnw=0, addr=0x50, data=0xA5.
  -> req_ready[0] pulses at accept.
  -> m_write_en=1, m_addr=0x50, m_data=0xA5 next cycle, held until m_done (driven 10 cycles later).
  -> rsp_done[0]=1, rsp_err[0]=0 the next cycle; m_read_en stays 0.
- Read: req2 rnw=1, addr=0x3C.
  -> m_read_en=1 only, grant_id=2, rsp_done[2] after m_done.
- Round-robin: all four req_valid held high, m_done 3 cycles after each issue.
  -> grant order 0,1,2,3,0; each ready pulse exactly once per grant.
- Busy gating: bus_busy=1 for 20 cycles with req1 valid.
  -> no req_ready and no enables.
  -> bus_busy=0 gives req_ready[1] that same cycle, enable the next.
- Timeout: TIMEOUT_CYC=16, req3 write, m_done never asserted.
  -> enable high exactly 16 cycles, then rsp_done[3]=1 and rsp_err[3]=1.
  -> m_done in the 16th cycle instead gives err=0.
- Reset mid-CMD: assert rst 5 cycles into a req1 command.
  -> enables, active, and rsp_* are 0 after the edge; no rsp_done[1].
  -> With req0 and req1 then valid, req0 is granted first.
